adder_operand_recover: RTL and testbench



---
 rtl/adder_operand_recover.sv | 103 ++++++++++
 tb/tb_adder_operand_recover.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/adder_operand_recover.sv
// adder_operand_recover: recovers b = y - a from a widened sum and one addend.
// Chunk-serial subtractor, CHUNK_WIDTH bits per cycle, with a registered borrow
// chain. The request side and the result side each use a valid/ready handshake.
// The block holds one operation at a time.
module adder_operand_recover #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH:0]   y,
  input  logic [DATA_WIDTH-1:0] a,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] b,
  output logic                  err
);

  // Number of chunks: ceil((DATA_WIDTH+1)/CHUNK_WIDTH). The top chunk is zero-padded.
  localparam int N  = (DATA_WIDTH + CHUNK_WIDTH) / CHUNK_WIDTH;
  localparam int PW = N * CHUNK_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     y_q, a_q, diff_q, diff_nxt;
  logic              borrow, borrow_nxt;
  logic [IW-1:0]     idx;
  logic              last;
  logic [CHUNK_WIDTH:0] sub;

  // Handshake outputs come straight from the state register, so no input reaches an output combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Subtract one chunk. The operand registers shift right each cycle, so chunk i is always in the low CHUNK_WIDTH bits.
  always_comb begin
    sub        = {1'b0, y_q[CHUNK_WIDTH-1:0]} - {1'b0, a_q[CHUNK_WIDTH-1:0]}
               - {{CHUNK_WIDTH{1'b0}}, borrow};
    borrow_nxt = sub[CHUNK_WIDTH];
    // Each result chunk enters at the top. After N shifts, chunk 0 is in the low bits.
    diff_nxt   = (diff_q >> CHUNK_WIDTH)
               | (PW'(sub[CHUNK_WIDTH-1:0]) << (PW - CHUNK_WIDTH));
    last       = (idx == IW'(N - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture the operands on acceptance, step the borrow chain in CALC, and latch the result on the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      a_q    <= '0;
      diff_q <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      b      <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          y_q    <= PW'(y);
          a_q    <= PW'(a);
          diff_q <= '0;
          borrow <= 1'b0;
          idx    <= '0;
        end
        CALC: begin
          y_q    <= y_q >> CHUNK_WIDTH;
          a_q    <= a_q >> CHUNK_WIDTH;
          diff_q <= diff_nxt;
          borrow <= borrow_nxt;
          idx    <= idx + IW'(1);
          if (last) begin
            b   <= diff_nxt[DATA_WIDTH-1:0];
            // err is set when y < a (borrow out of the padded word) or when the difference needs bit DATA_WIDTH.
            err <= borrow_nxt | diff_nxt[DATA_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_operand_recover.sv
// Directed and round-trip bench for adder_operand_recover (DATA_WIDTH=32, CHUNK_WIDTH=8).
module tb_adder_operand_recover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [32:0] y_i;
  logic [31:0] a_i;
  logic        out_valid, out_ready;
  logic [31:0] b_o;
  logic        err_o;

  int nvec = 0;
  int nerr = 0;

  adder_operand_recover #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .y(y_i), .a(a_i),
    .out_valid(out_valid), .out_ready(out_ready), .b(b_o), .err(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a request, wait until it is accepted, then scramble y/a so the bench can show they are not sampled again.
  task automatic send(input logic [32:0] y, input logic [31:0] a, input bit rnd);
    int n = 0;
    if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; y_i = y; a_i = a;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    y_i = {1'b1, $urandom()}; a_i = $urandom();
  endtask

  // Wait for the result, check it on the cycle the transfer completes, and return just after that edge.
  task automatic collect(input logic [31:0] eb, input logic ee, input string tag, input bit rnd);
    int  n = 0;
    bit  done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        chk({tag, "_b"}, 64'(b_o), 64'(eb));
        chk({tag, "_err"}, 64'(err_o), 64'(ee));
        done = 1;
      end
      n++;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int c;
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; y_i = '0; a_i = '0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_b", 64'(b_o), 0);
    chk("rst_err", 64'(err_o), 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: basic case, plus latency and single-cycle out_valid
    out_ready = 1'b1;
    send(33'h0_0000_0005, 32'h3, 0);
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin c = i; break; end
    end
    chk("t1_latency", 64'(c), 5);
    chk("t1_b", 64'(b_o), 64'h2);
    chk("t1_err", 64'(err_o), 0);
    @(posedge clk); #1;
    chk("t1_ov_drop", 64'(out_valid), 0);
    chk("t1_in_ready", 64'(in_ready), 1);

    // 2: borrow in every chunk, and a sum that uses bit 32
    send(33'h1_FFFF_FFFE, 32'hFFFF_FFFF, 0);
    collect(32'hFFFF_FFFF, 1'b0, "t2", 0);

    // 3: underflow, then a result too wide for 32 bits
    send(33'h0_0000_0002, 32'h5, 0);
    collect(32'hFFFF_FFFD, 1'b1, "t3a", 0);
    send(33'h1_0000_0005, 32'h1, 0);
    collect(32'h0000_0004, 1'b1, "t3b", 0);

    // 4: backpressure while in_valid toggles and y/a change
    out_ready = 1'b0;
    send(33'h0_8000_0000, 32'h1234_5678, 0);
    c = 0;
    while (!out_valid && c < 50) begin @(negedge clk); c++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0]; y_i = {1'b0, $urandom()}; a_i = $urandom();
      chk("t4_hold_ov", 64'(out_valid), 1);
      chk("t4_hold_b", 64'(b_o), 64'h6DCB_A988);
      chk("t4_hold_err", 64'(err_o), 0);
      chk("t4_in_ready", 64'(in_ready), 0);
    end
    @(negedge clk); in_valid = 1'b0;
    collect(32'h6DCB_A988, 1'b0, "t4", 0);
    chk("t4_no_second", 64'(out_valid), 0);
    @(negedge clk);
    chk("t4_idle_ready", 64'(in_ready), 1);
    send(33'h0_0000_1000, 32'h0000_0001, 0);
    collect(32'h0000_0FFF, 1'b0, "t4_fresh", 0);

    // 5: asynchronous reset during the second CALC cycle
    out_ready = 1'b0;
    send(33'h1_2345_6789, 32'h1, 0);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("t5_ov", 64'(out_valid), 0);
    chk("t5_b", 64'(b_o), 0);
    chk("t5_err", 64'(err_o), 0);
    @(negedge clk); rst_n = 1'b1;
    chk("t5_in_ready", 64'(in_ready), 1);
    repeat (8) @(negedge clk);
    chk("t5_no_result", 64'(out_valid), 0);
    send(33'h0_0000_0100, 32'h1, 0);
    collect(32'h0000_00FF, 1'b0, "t5", 0);

    // 6: round trip, with corners a=0 and b=0 first
    send({1'b0, 32'hCAFE_F00D}, 32'h0, 1);
    collect(32'hCAFE_F00D, 1'b0, "t6_a0", 1);
    send({1'b0, 32'hCAFE_F00D}, 32'hCAFE_F00D, 1);
    collect(32'h0, 1'b0, "t6_b0", 1);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom(); rb = $urandom();
      send({1'b0, ra} + {1'b0, rb}, ra, 1);
      collect(rb, 1'b0, "t6_rt", 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
